// File: rtl/tx_serializer_if.sv
// Serializer bus: parallel word handshake in, serial bit stream out.
// Handshake: a word transfers on a rising clk edge where tx_valid && tx_ready;
// the producer holds tx_data stable while tx_valid is high and tx_ready is low,
// and tx_data is ignored whenever tx_ready is low.
// state_dbg mirrors the serializer FSM (0 = IDLE, 1 = SHIFT) for checkers.
interface tx_serializer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              sdo;
  logic              sdo_en;
  logic              tx_done;
  logic              busy;
  logic              state_dbg;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  sdo,
    input  sdo_en,
    input  tx_done,
    input  busy,
    input  state_dbg
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output sdo,
    output sdo_en,
    output tx_done,
    output busy,
    output state_dbg
  );
endinterface

// File: rtl/tx_serializer.sv
// Parallel-to-serial transmitter with a shifter plus one holding buffer, so
// consecutive words go out back-to-back with no idle gap.
// Optional feature: define TX_SERIALIZER_PARITY_EN to append an even-parity
// bit (XOR of the data word) after the data bits of each frame.
module tx_serializer #(
  parameter int   DATA_W    = 8,
  parameter bit   LSB_FIRST = 1'b0,
  parameter logic IDLE_LVL  = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  tx_serializer_if.slave bus
);

`ifdef TX_SERIALIZER_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int FRAME_LEN = DATA_W + PAR_W;
  localparam int CW        = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST_IDX     = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] PRE_LAST_IDX = CW'(FRAME_LEN - 2);
`ifdef TX_SERIALIZER_PARITY_EN
  localparam logic [CW-1:0] LAST_DATA_IDX = CW'(DATA_W - 1);
`endif

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] buf_data;
  logic              buf_full;
  logic [CW-1:0]     cnt;          // index of the frame bit currently on sdo
  logic              sdo_q;
  logic              sdo_en_q;
  logic              tx_done_q;
`ifdef TX_SERIALIZER_PARITY_EN
  logic              parity;
`endif

  logic              accept;
  logic              last;
  logic              load_new;
  logic              load_buf;
  logic              to_buf;
  logic              load;
  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] load_shifted;
  logic [DATA_W-1:0] shreg_shifted;
  logic              load_first;
  logic              next_sdo;

  // A new word goes straight to the shifter when idle or when the current
  // frame is on its last bit; otherwise it waits in the holding buffer.
  assign accept    = bus.tx_valid && !buf_full;
  assign last      = (state == SHIFT) && (cnt == LAST_IDX);
  assign load_new  = accept && ((state == IDLE) || last);
  assign load_buf  = last && buf_full;
  assign to_buf    = accept && (state == SHIFT) && !last;
  assign load      = load_new || load_buf;
  assign load_word = load_buf ? buf_data : bus.tx_data;

  // Bit ordering: pick the first bit of a loaded word and the next bit of the
  // running shifter; the parity bit follows the final data bit.
  always_comb begin
    if (LSB_FIRST) begin
      load_first    = load_word[0];
      load_shifted  = load_word >> 1;
      shreg_shifted = shreg >> 1;
      next_sdo      = shreg[0];
    end else begin
      load_first    = load_word[DATA_W-1];
      load_shifted  = load_word << 1;
      shreg_shifted = shreg << 1;
      next_sdo      = shreg[DATA_W-1];
    end
`ifdef TX_SERIALIZER_PARITY_EN
    if (cnt == LAST_DATA_IDX) next_sdo = parity;
`endif
  end

  // FSM, shifter, holding buffer and registered serial outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      buf_data  <= '0;
      buf_full  <= 1'b0;
      cnt       <= '0;
      sdo_q     <= IDLE_LVL;
      sdo_en_q  <= 1'b0;
      tx_done_q <= 1'b0;
`ifdef TX_SERIALIZER_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      if (to_buf) begin
        buf_data <= bus.tx_data;
        buf_full <= 1'b1;
      end else if (load_buf) begin
        buf_full <= 1'b0;
      end

      if (load) begin
        state     <= SHIFT;
        shreg     <= load_shifted;
        sdo_q     <= load_first;
        sdo_en_q  <= 1'b1;
        cnt       <= '0;
        tx_done_q <= 1'b0;
`ifdef TX_SERIALIZER_PARITY_EN
        parity    <= ^load_word;
`endif
      end else if (last) begin
        state     <= IDLE;
        shreg     <= '0;
        sdo_q     <= IDLE_LVL;
        sdo_en_q  <= 1'b0;
        cnt       <= '0;
        tx_done_q <= 1'b0;
      end else if (state == SHIFT) begin
        shreg     <= shreg_shifted;
        sdo_q     <= next_sdo;
        cnt       <= cnt + 1'b1;
        tx_done_q <= (cnt == PRE_LAST_IDX);
      end
    end
  end

  assign bus.tx_ready  = !buf_full;
  assign bus.busy      = (state == SHIFT) || buf_full;
  assign bus.sdo       = sdo_q;
  assign bus.sdo_en    = sdo_en_q;
  assign bus.tx_done   = tx_done_q;
  assign bus.state_dbg = (state == SHIFT);

endmodule

// File: tb/tb_tx_serializer.sv
// Bench for tx_serializer: two instances (MSB-first / idle-low and
// LSB-first / idle-high) share one stimulus stream and are compared every
// cycle against a word-queue model of the frame stream.
// Honours TX_SERIALIZER_PARITY_EN the same way as the design.
module tb_tx_serializer;
  localparam int DW = 8;
`ifdef TX_SERIALIZER_PARITY_EN
  localparam int FL = DW + 1;
`else
  localparam int FL = DW;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tx_serializer_if #(.DATA_W(DW)) bus0 ();
  tx_serializer_if #(.DATA_W(DW)) bus1 ();

  tx_serializer #(.DATA_W(DW), .LSB_FIRST(1'b0), .IDLE_LVL(1'b0)) u_msb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  tx_serializer #(.DATA_W(DW), .LSB_FIRST(1'b1), .IDLE_LVL(1'b1)) u_lsb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] exp_q[$];   // accepted words not yet on the wire
  logic [DW-1:0] m_cur;      // word currently being sent
  bit            m_active;
  int            m_idx;      // frame bit index currently on the wire

  logic [FL-1:0] cap_msb;
  logic [FL-1:0] cap_lsb;
  int            ncap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_bit(input bit lsb, input logic [DW-1:0] w, input int idx);
    if (idx >= DW) return ^w;
    return lsb ? w[idx] : w[DW-1-idx];
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_active = 1'b0;
    m_idx = 0;
    m_cur = '0;
  endtask

  // One clock edge of the model: an offered word is taken if nothing is
  // waiting; a frame ends after FL bits and the next waiting word follows.
  task automatic model_step(input bit v, input logic [DW-1:0] d);
    if (v && exp_q.size() == 0) exp_q.push_back(d);
    if (!m_active || m_idx == FL - 1) begin
      if (exp_q.size() > 0) begin
        m_cur = exp_q.pop_front();
        m_idx = 0;
        m_active = 1'b1;
      end else begin
        m_active = 1'b0;
        m_idx = 0;
      end
    end else begin
      m_idx++;
    end
  endtask

  task automatic check_dut(input string name, input bit lsb, input logic idle,
                           input logic sdo, input logic sdo_en, input logic done,
                           input logic busy, input logic ready, input logic st);
    check({name, ".sdo_en"}, {31'd0, sdo_en}, {31'd0, m_active});
    check({name, ".sdo"}, {31'd0, sdo},
          {31'd0, m_active ? exp_bit(lsb, m_cur, m_idx) : idle});
    check({name, ".tx_done"}, {31'd0, done}, {31'd0, m_active && m_idx == FL - 1});
    check({name, ".busy"}, {31'd0, busy}, {31'd0, m_active || exp_q.size() > 0});
    check({name, ".tx_ready"}, {31'd0, ready}, {31'd0, exp_q.size() == 0});
    check({name, ".state"}, {31'd0, st}, {31'd0, m_active});
  endtask

  task automatic check_cycle();
    check_dut("msb", 1'b0, 1'b0, bus0.sdo, bus0.sdo_en, bus0.tx_done,
              bus0.busy, bus0.tx_ready, bus0.state_dbg);
    check_dut("lsb", 1'b1, 1'b1, bus1.sdo, bus1.sdo_en, bus1.tx_done,
              bus1.busy, bus1.tx_ready, bus1.state_dbg);
    if (bus0.sdo_en) cap_msb = {cap_msb[FL-2:0], bus0.sdo};
    if (bus1.sdo_en) begin
      if (ncap < FL) cap_lsb[ncap] = bus1.sdo;
      ncap++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input logic [DW-1:0] d);
    bus0.tx_valid = v;
    bus1.tx_valid = v;
    bus0.tx_data  = d;
    bus1.tx_data  = d;
  endtask

  // Called at a falling edge: drive, advance one clock, check outputs.
  task automatic cycle(input bit v, input logic [DW-1:0] d);
    drive(v, d);
    model_step(v, d);
    @(posedge clk);
    @(negedge clk);
    check_cycle();
  endtask

  // Reset asserted mid-cycle; outputs must fall back without a clock edge.
  task automatic async_reset();
    drive(1'b0, '0);
    model_step(1'b0, '0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst.msb.sdo", {31'd0, bus0.sdo}, 32'd0);
    check("rst.lsb.sdo", {31'd0, bus1.sdo}, 32'd1);
    check("rst.msb.sdo_en", {31'd0, bus0.sdo_en}, 32'd0);
    check("rst.msb.busy", {31'd0, bus0.busy}, 32'd0);
    check("rst.msb.tx_ready", {31'd0, bus0.tx_ready}, 32'd1);
    check("rst.msb.tx_done", {31'd0, bus0.tx_done}, 32'd0);
    check("rst.lsb.busy", {31'd0, bus1.busy}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_cycle();
  endtask

  // Send one word from idle and check the captured frame as a whole.
  task automatic send_idle(input logic [DW-1:0] d);
    cap_msb = '0;
    cap_lsb = '0;
    ncap = 0;
    cycle(1'b1, d);
    repeat (FL + 1) cycle(1'b0, '0);
    check("frame.len", ncap, FL);
    check("frame.msb", {24'd0, cap_msb[FL-1 -: DW]}, {24'd0, d});
    check("frame.lsb", {24'd0, cap_lsb[DW-1:0]}, {24'd0, d});
`ifdef TX_SERIALIZER_PARITY_EN
    check("frame.par.msb", {31'd0, cap_msb[0]}, {31'd0, ^d});
    check("frame.par.lsb", {31'd0, cap_lsb[DW]}, {31'd0, ^d});
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pct[4] = '{80, 30, 100, 10};
    drive(1'b0, '0);
    model_reset();
    cap_msb = '0;
    cap_lsb = '0;
    ncap = 0;
    repeat (2) @(negedge clk);
    check_cycle();
    rst_n = 1'b1;
    check_cycle();

    // single words from idle
    send_idle(8'hA5);
    check("a5.bits", {24'd0, cap_msb[FL-1 -: DW]}, 32'h0000_00A5);
    send_idle(8'h01);
    check("01.lsb_first", {24'd0, cap_lsb[DW-1:0]}, 32'h0000_0001);
    send_idle(8'h00);
`ifdef TX_SERIALIZER_PARITY_EN
    send_idle(8'h07);
    check("par07", {31'd0, cap_msb[0]}, 32'd1);
    send_idle(8'h03);
    check("par03", {31'd0, cap_msb[0]}, 32'd0);
`endif

    // back-to-back: FF, then 00 while shifting, then 3C held until taken
    cycle(1'b1, 8'hFF);
    cycle(1'b1, 8'h00);
    for (int i = 0; i < 4 * FL; i++) begin
      bit rdy = (exp_q.size() == 0);
      cycle(1'b1, 8'h3C);
      if (rdy) break;
    end
    repeat (3 * FL) cycle(1'b0, '0);

    // reset in the middle of 8'hC3, then 8'h81 must go out intact
    cycle(1'b1, 8'hC3);
    repeat (3) cycle(1'b0, '0);
    async_reset();
    send_idle(8'h81);

    // random traffic at several offered loads
    for (int p = 0; p < 4; p++) begin
      for (int n = 0; n < 150; n++) begin
        cycle($urandom_range(0, 99) < pct[p], DW'($urandom));
        if (p == 2 && n == 77) async_reset();
      end
    end
    repeat (3 * FL) cycle(1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
